// File: rtl/noc_output_arbiter.sv
// Round-robin output-port arbiter with burst limiting for the 32-bit NoC switch.
// Define NOC_ARB_STATS_EN to add the o_xfer_count / o_stall_count statistics outputs.
module noc_output_arbiter #(
    parameter int DataWidth = 32,
    parameter int NumReq    = 4,
    parameter int MaxBurst  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NumReq*DataWidth-1:0]   i_data,
    input  logic [NumReq-1:0]             i_data_valid,
    output logic [NumReq-1:0]             o_data_ready,
    output logic [DataWidth-1:0]          o_data,
    output logic                          o_data_valid,
    input  logic                          i_data_ready,
    output logic [NumReq-1:0]             o_grant,
    output logic                          o_busy
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [31:0]                   o_xfer_count,
    output logic [31:0]                   o_stall_count
`endif
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [IdxW-1:0]     idx_r, idx_s, rr_r, rr_s, ptr_s, sel_s, cand_s;
    logic [NumReq-1:0]   grant_r, grant_s, mask_s;
    logic [7:0]          burst_r, burst_s;
    logic                busy_s, cur_valid_s, xfer_s, last_beat_s, drop_s, release_s;
    logic                found_s, hit_s;

    function automatic logic [IdxW-1:0] wrap_idx(input int v);
        int w;
        w = (v >= NumReq) ? (v - NumReq) : v;
        return IdxW'(w);
    endfunction

    function automatic logic [NumReq-1:0] onehot(input logic [IdxW-1:0] i);
        logic [NumReq-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Transfer and release conditions for the currently held grant
    always_comb begin
        busy_s      = (state_r == ST_GRANT);
        cur_valid_s = busy_s & i_data_valid[idx_r];
        xfer_s      = cur_valid_s & i_data_ready;
        last_beat_s = xfer_s & (burst_r == 8'(MaxBurst - 1));
        drop_s      = busy_s & ~i_data_valid[idx_r];
        release_s   = last_beat_s | drop_s;
    end

    // On release the search starts past the old owner; an emptied owner is excluded
    always_comb begin
        if (release_s) begin
            ptr_s = (idx_r == IdxW'(NumReq - 1)) ? '0 : (idx_r + IdxW'(1'b1));
        end else begin
            ptr_s = rr_r;
        end
        if (drop_s) begin
            mask_s = i_data_valid & ~onehot(idx_r);
        end else begin
            mask_s = i_data_valid;
        end
    end

    // Wrapping priority search; scanning backwards leaves the closest hit in sel_s
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            cand_s  = wrap_idx(int'(ptr_s) + i);
            hit_s   = mask_s[cand_s];
            found_s = found_s | hit_s;
            sel_s   = hit_s ? cand_s : sel_s;
        end
    end

    // Next-state logic: grant from IDLE, hold, count beats, or hand over without a bubble
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        grant_s = grant_r;
        rr_s    = rr_r;
        burst_s = burst_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s = ST_GRANT;
                    idx_s   = sel_s;
                    grant_s = onehot(sel_s);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    rr_s    = ptr_s;
                    burst_s = 8'd0;
                    if (found_s) begin
                        idx_s   = sel_s;
                        grant_s = onehot(sel_s);
                    end else begin
                        state_s = ST_IDLE;
                        grant_s = '0;
                    end
                end else if (xfer_s) begin
                    burst_s = burst_r + 8'd1;
                end else begin
                    burst_s = burst_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = '0;
            end
        endcase
    end

    // Arbitration state registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            grant_r <= '0;
            rr_r    <= '0;
            burst_r <= 8'd0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            grant_r <= grant_s;
            rr_r    <= rr_s;
            burst_r <= burst_s;
        end
    end

    // Link mux driven straight from the registered grant
    always_comb begin
        o_data       = i_data[int'(idx_r)*DataWidth +: DataWidth];
        o_data_valid = cur_valid_s;
        if (busy_s) begin
            o_data_ready = grant_r & {NumReq{i_data_ready}};
        end else begin
            o_data_ready = '0;
        end
    end

    assign o_grant = grant_r;
    assign o_busy  = busy_s;

`ifdef NOC_ARB_STATS_EN
    logic [31:0] xfer_cnt_r, stall_cnt_r;

    // Free-running transfer and stall counters, wrapping naturally
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            xfer_cnt_r  <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            if (xfer_s) begin
                xfer_cnt_r <= xfer_cnt_r + 32'd1;
            end
            if (cur_valid_s & ~i_data_ready) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    assign o_xfer_count  = xfer_cnt_r;
    assign o_stall_count = stall_cnt_r;
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: per-cycle reference model plus directed literal checks.
module tb_noc_output_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              i_reset;
    logic [DW-1:0]     dat [N];
    logic [N*DW-1:0]   i_data;
    logic [N-1:0]      i_data_valid;
    logic [N-1:0]      o_data_ready;
    logic [DW-1:0]     o_data;
    logic              o_data_valid;
    logic              i_data_ready;
    logic [N-1:0]      o_grant;
    logic              o_busy;
`ifdef NOC_ARB_STATS_EN
    logic [31:0]       o_xfer_count;
    logic [31:0]       o_stall_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int          m_g   = -1;
    int          m_ptr = 0;
    int          m_cnt = 0;
    logic [31:0] m_xfer  = 32'd0;
    logic [31:0] m_stall = 32'd0;

    assign i_data = {dat[3], dat[2], dat[1], dat[0]};

    noc_output_arbiter #(.DataWidth(DW), .NumReq(N), .MaxBurst(MB)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
        .o_grant      (o_grant),
        .o_busy       (o_busy)
`ifdef NOC_ARB_STATS_EN
        ,
        .o_xfer_count (o_xfer_count),
        .o_stall_count(o_stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input int ptr, input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            if (m[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: compare at every falling edge, then advance to the next rising edge
    initial begin
        logic [N-1:0] eg, er, mk;
        logic         ev;
        forever begin
            @(negedge clk);
            if (i_reset) begin
                m_g = -1; m_ptr = 0; m_cnt = 0; m_xfer = 32'd0; m_stall = 32'd0;
            end
            eg = (m_g >= 0) ? N'(4'b0001 << m_g) : '0;
            ev = (m_g >= 0) ? i_data_valid[m_g] : 1'b0;
            er = (m_g >= 0 && i_data_ready) ? eg : '0;
            check("m_grant", 32'(o_grant), 32'(eg));
            check("m_busy", 32'(o_busy), 32'(m_g >= 0));
            check("m_valid", 32'(o_data_valid), 32'(ev));
            check("m_ready", 32'(o_data_ready), 32'(er));
            if (ev) check("m_data", o_data, dat[m_g]);
`ifdef NOC_ARB_STATS_EN
            check("m_xfer_count", o_xfer_count, m_xfer);
            check("m_stall_count", o_stall_count, m_stall);
`endif
            if (!i_reset) begin
                if (ev && i_data_ready) m_xfer = m_xfer + 32'd1;
                if (ev && !i_data_ready) m_stall = m_stall + 32'd1;
                if (m_g < 0) begin
                    m_g = search(m_ptr, i_data_valid);
                end else if (!i_data_valid[m_g]) begin
                    m_ptr = (m_g + 1) % N;
                    m_cnt = 0;
                    mk = i_data_valid & ~N'(4'b0001 << m_g);
                    m_g = search(m_ptr, mk);
                end else if (i_data_ready) begin
                    if (m_cnt == MB - 1) begin
                        m_ptr = (m_g + 1) % N;
                        m_cnt = 0;
                        m_g = search(m_ptr, i_data_valid);
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        i_data_valid = 4'b0000;
        i_data_ready = 1'b0;
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
    endtask

    initial begin
        dat[0] = 32'h0100_0011;
        dat[1] = 32'h0200_0022;
        dat[2] = 32'h0300_00AA;
        dat[3] = 32'h0400_0044;
        i_reset = 1'b1;
        i_data_valid = 4'b0000;
        i_data_ready = 1'b0;
        step();
        step();
        check("rst_grant", 32'(o_grant), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_valid", 32'(o_data_valid), 32'h0);
        check("rst_ready", 32'(o_data_ready), 32'h0);
        i_reset = 1'b0;
        step();

        // Basic grant on requester 2
        i_data_valid = 4'b0100;
        i_data_ready = 1'b1;
        step();
        check("basic_grant", 32'(o_grant), 32'h4);
        check("basic_data", o_data, 32'h0300_00AA);
        check("basic_ready", 32'(o_data_ready), 32'h4);
        i_data_valid = 4'b0000;
        step();
        step();

        // Round robin with all requesters busy
        do_reset();
        i_data_valid = 4'b1111;
        i_data_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("rr_grant", 32'(o_grant), 32'(4'b0001 << ((i / 4) % 4)));
            check("rr_valid", 32'(o_data_valid), 32'h1);
        end

        // Backpressure on requester 1, then check the burst count was frozen
        do_reset();
        i_data_valid = 4'b0010;
        i_data_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_grant", 32'(o_grant), 32'h2);
            check("bp_data", o_data, 32'h0200_0022);
            check("bp_valid", 32'(o_data_valid), 32'h1);
        end
`ifdef NOC_ARB_STATS_EN
        check("bp_stall_count", o_stall_count, 32'd5);
`endif
        i_data_valid = 4'b1010;
        i_data_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_grant", 32'(o_grant), 32'h2);
        end
        step();
        check("bp_rotate_grant", 32'(o_grant), 32'h8);
`ifdef NOC_ARB_STATS_EN
        check("bp_xfer_count", o_xfer_count, 32'd4);
`endif

        // Valid drop on requester 3 after two beats hands straight to 0
        i_data_valid = 4'b1001;
        step();
        step();
        check("drop_before", 32'(o_grant), 32'h8);
        i_data_valid = 4'b0001;
        step();
        check("drop_grant", 32'(o_grant), 32'h1);
        check("drop_busy", 32'(o_busy), 32'h1);
        i_data_valid = 4'b0110;
        step();
        check("drop_next_ptr", 32'(o_grant), 32'h2);
        i_data_valid = 4'b0000;
        step();

        // Sole requester keeps streaming across burst boundaries
        do_reset();
        i_data_valid = 4'b0010;
        i_data_ready = 1'b1;
        step();
        check("sole_first", 32'(o_grant), 32'h2);
        for (int i = 0; i < 10; i++) begin
            step();
            check("sole_grant", 32'(o_grant), 32'h2);
            check("sole_valid", 32'(o_data_valid), 32'h1);
        end
`ifdef NOC_ARB_STATS_EN
        check("sole_xfer_count", o_xfer_count, 32'd10);
`endif

        // Asynchronous reset in the middle of the burst
        #1;
        i_reset = 1'b1;
        #1;
        check("arst_grant", 32'(o_grant), 32'h0);
        check("arst_valid", 32'(o_data_valid), 32'h0);
        check("arst_ready", 32'(o_data_ready), 32'h0);
        i_data_valid = 4'b0101;
        step();
        i_reset = 1'b0;
        step();
        check("arst_first_grant", 32'(o_grant), 32'h1);
        check("arst_first_data", o_data, 32'h0100_0011);
        i_data_valid = 4'b0000;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
